// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types for the packet frame checker.
// FSM state encoding and completion-record error codes.
package pkt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_FRAME  = 2'd1;
    localparam logic [1:0] ERR_NOTAIL = 2'd2;
    localparam logic [1:0] ERR_OVFL   = 2'd3;

endpackage

// File: rtl/pkt_sat_cnt.sv
// pkt_sat_cnt: saturating up-counter with asynchronous active-high reset.
// Counts inc pulses and sticks at all-ones.
module pkt_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Increment on request unless already at the top value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pkt_frame_checker.sv
// pkt_frame_checker: watches the head/valid/tail channel, enforces framing,
// measures each packet's length and XOR checksum, and emits one completion
// record per packet plus saturating good/error counters.
// Optional feature macro: PKT_CSUM_EN (checksum accumulator; pkt_csum is 0
// when undefined).
module pkt_frame_checker
    import pkt_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              head,
    input  logic              tail,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [DATA_W-1:0] pkt_csum,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next, len_inc;
    logic [DATA_W-1:0] csum_reg, csum_next, csum_acc;
    logic [DATA_W-1:0] beat_data;

    logic              busy_reg, done_reg, err_reg;
    logic [1:0]        code_reg;
    logic [LEN_W-1:0]  plen_reg;
    logic [DATA_W-1:0] pcsum_reg;

    logic              rec_fire, rec_err;
    logic [1:0]        rec_code;
    logic [LEN_W-1:0]  rec_len;
    logic [DATA_W-1:0] rec_csum;

`ifdef PKT_CSUM_EN
    assign beat_data = data;
`else
    // Feeding zeros collapses the whole accumulator to constants.
    assign beat_data = '0;
    logic unused_data;
    assign unused_data = ^data;
`endif

    assign len_inc  = len_reg + LEN_W'(1);
    assign csum_acc = csum_reg ^ beat_data;

    // Decide the next packet state and whether this beat closes a record.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        csum_next  = csum_reg;
        rec_fire   = 1'b0;
        rec_err    = 1'b0;
        rec_code   = ERR_NONE;
        rec_len    = len_inc;
        rec_csum   = csum_acc;
        if (valid) begin
            case (state_reg)
                S_BODY: begin
                    if (head) begin
                        // Missing tail: report the open packet, restart on this head.
                        rec_fire  = 1'b1;
                        rec_err   = 1'b1;
                        rec_code  = ERR_NOTAIL;
                        rec_len   = len_reg;
                        rec_csum  = csum_reg;
                        len_next  = LEN_ONE;
                        csum_next = beat_data;
                    end else if (tail) begin
                        rec_fire   = 1'b1;
                        state_next = S_IDLE;
                    end else if (len_inc == LEN_MAX) begin
                        // No room left for a tail beat.
                        rec_fire   = 1'b1;
                        rec_err    = 1'b1;
                        rec_code   = ERR_OVFL;
                        state_next = S_DROP;
                    end else begin
                        len_next  = len_inc;
                        csum_next = csum_acc;
                    end
                end
                default: begin
                    if (head && !tail) begin
                        state_next = S_BODY;
                        len_next   = LEN_ONE;
                        csum_next  = beat_data;
                    end else if ((state_reg == S_DROP) && !head) begin
                        if (tail) begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        // Single-beat packet or orphan beat outside a packet.
                        rec_fire   = 1'b1;
                        rec_err    = 1'b1;
                        rec_code   = ERR_FRAME;
                        rec_len    = LEN_ONE;
                        rec_csum   = beat_data;
                        state_next = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Register FSM state, accumulators and the completion record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            len_reg   <= '0;
            csum_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
            plen_reg  <= '0;
            pcsum_reg <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            csum_reg  <= csum_next;
            busy_reg  <= (state_next == S_BODY);
            done_reg  <= rec_fire;
            if (rec_fire) begin
                err_reg   <= rec_err;
                code_reg  <= rec_code;
                plen_reg  <= rec_len;
                pcsum_reg <= rec_csum;
            end
        end
    end

    pkt_sat_cnt #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rec_fire && !rec_err),
        .count (good_cnt)
    );

    pkt_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rec_fire && rec_err),
        .count (err_cnt)
    );

    assign busy     = busy_reg;
    assign pkt_done = done_reg;
    assign pkt_err  = err_reg;
    assign err_code = code_reg;
    assign pkt_len  = plen_reg;
    assign pkt_csum = pcsum_reg;

endmodule

// File: tb/tb_pkt_frame_checker.sv
// Testbench for pkt_frame_checker: directed beats, a packet-level model built
// on a queue of accepted beats, a per-cycle compare process and literal pins.
module tb_pkt_frame_checker;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              valid = 1'b0;
    logic              head = 1'b0;
    logic              tail = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              busy, pkt_done, pkt_err;
    logic [1:0]        err_code;
    logic [LEN_W-1:0]  pkt_len;
    logic [DATA_W-1:0] pkt_csum;
    logic [CNT_W-1:0]  good_cnt, err_cnt;

    always #5 clk = ~clk;

    pkt_frame_checker #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .head(head), .tail(tail),
        .data(data), .busy(busy), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_code(err_code), .pkt_len(pkt_len), .pkt_csum(pkt_csum),
        .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Packet-level model: the beats of the open packet, plus flags.
    int open_q[$];
    bit m_open, m_drop;
    int exp_busy, exp_done, exp_err, exp_code, exp_len, exp_csum, exp_good, exp_errc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cs(input int v);
`ifdef PKT_CSUM_EN
        return v & 8'hFF;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int q_xor();
        int r = 0;
        foreach (open_q[i]) r ^= open_q[i];
        return r;
    endfunction

    function automatic void emit(input int is_err, input int code, input int len, input int sum);
        exp_done = 1;
        exp_err  = is_err;
        exp_code = code;
        exp_len  = len;
        exp_csum = cs(sum);
        if (is_err != 0) exp_errc = (exp_errc >= CMAX) ? CMAX : exp_errc + 1;
        else             exp_good = (exp_good >= CMAX) ? CMAX : exp_good + 1;
    endfunction

    function automatic void model_reset();
        open_q.delete();
        m_open = 0; m_drop = 0;
        exp_busy = 0; exp_done = 0; exp_err = 0; exp_code = 0;
        exp_len = 0; exp_csum = 0; exp_good = 0; exp_errc = 0;
    endfunction

    function automatic void model_step(input bit v, input bit h, input bit t, input int d);
        exp_done = 0;
        if (v) begin
            if (m_open) begin
                if (h) begin
                    emit(1, 2, open_q.size(), q_xor());
                    open_q.delete();
                    open_q.push_back(d);
                end else begin
                    open_q.push_back(d);
                    if (t) begin
                        emit(0, 0, open_q.size(), q_xor());
                        open_q.delete();
                        m_open = 0;
                    end else if (open_q.size() == MAX_LEN) begin
                        emit(1, 3, open_q.size(), q_xor());
                        open_q.delete();
                        m_open = 0;
                        m_drop = 1;
                    end
                end
            end else if (h && !t) begin
                m_open = 1; m_drop = 0;
                open_q.delete();
                open_q.push_back(d);
            end else if (m_drop && !h) begin
                if (t) m_drop = 0;
            end else begin
                emit(1, 1, 1, d);
                m_drop = 0;
            end
        end
        exp_busy = m_open ? 1 : 0;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     64'(busy),     64'(exp_busy));
            chk("pkt_done", 64'(pkt_done), 64'(exp_done));
            chk("pkt_err",  64'(pkt_err),  64'(exp_err));
            chk("err_code", 64'(err_code), 64'(exp_code));
            chk("pkt_len",  64'(pkt_len),  64'(exp_len));
            chk("pkt_csum", 64'(pkt_csum), 64'(exp_csum));
            chk("good_cnt", 64'(good_cnt), 64'(exp_good));
            chk("err_cnt",  64'(err_cnt),  64'(exp_errc));
        end
    end

    // One channel cycle: inputs change just after the falling edge.
    task automatic drive(input bit v, input bit h, input bit t, input int d);
        @(negedge clk); #1;
        valid = v; head = h; tail = t; data = DATA_W'(d);
        model_step(v, h, t, d);
        @(posedge clk); #1;
        $display("beat v=%0d h=%0d t=%0d d=%02h -> done=%0d err=%0d code=%0d len=%0d csum=%02h busy=%0d good=%0d errc=%0d",
                 v, h, t, d, pkt_done, pkt_err, err_code, pkt_len, pkt_csum, busy, good_cnt, err_cnt);
    endtask

    task automatic lit_rec(input string tag, input int e, input int code, input int len, input int sum);
        chk({tag, ".done"}, 64'(pkt_done), 64'd1);
        chk({tag, ".err"},  64'(pkt_err),  64'(e));
        chk({tag, ".code"}, 64'(err_code), 64'(code));
        chk({tag, ".len"},  64'(pkt_len),  64'(len));
        chk({tag, ".csum"}, 64'(pkt_csum), 64'(cs(sum)));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        valid = 0; head = 0; tail = 0; data = '0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(pkt_done), 64'd0);
        chk("rst.len", 64'(pkt_len), 64'd0);
        chk("rst.good", 64'(good_cnt), 64'd0);
        chk("rst.errc", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        $display("reset pulse applied");
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("init.busy", 64'(busy), 64'd0);
        chk("init.done", 64'(pkt_done), 64'd0);
        chk("init.good", 64'(good_cnt), 64'd0);
        @(negedge clk); #1;
        reset = 1'b0;

        // Basic good packet, with an ignored non-beat in the middle.
        drive(1, 1, 0, 'h11);
        chk("open.busy", 64'(busy), 64'd1);
        drive(1, 0, 0, 'h22);
        drive(0, 1, 1, 'hFF);
        drive(1, 0, 1, 'h44);
        lit_rec("good3", 0, 0, 3, 'h77);
        chk("good3.cnt", 64'(good_cnt), 64'd1);
        drive(0, 0, 0, 0);
        chk("pulse.done", 64'(pkt_done), 64'd0);
        chk("close.busy", 64'(busy), 64'd0);

        // Orphan tail and single-beat packet.
        drive(1, 0, 1, 'h05);
        lit_rec("orphan", 1, 1, 1, 'h05);
        drive(1, 1, 1, 'h09);
        lit_rec("single", 1, 1, 1, 'h09);
        chk("single.errc", 64'(err_cnt), 64'd2);

        // Missing tail, then back-to-back good packet.
        drive(1, 1, 0, 'hA0);
        drive(1, 0, 0, 'h0B);
        drive(1, 1, 0, 'h01);
        lit_rec("notail", 1, 2, 2, 'hAB);
        chk("notail.busy", 64'(busy), 64'd1);
        drive(1, 0, 1, 'h02);
        lit_rec("b2b", 0, 0, 2, 'h03);

        // Overflow, drop, then head opens directly from drop.
        drive(1, 1, 0, 'h80);
        for (int i = 1; i <= 14; i++) drive(1, 0, 0, i);
        chk("pre_ovfl.busy", 64'(busy), 64'd1);
        drive(1, 0, 0, 15);
        lit_rec("ovfl", 1, 3, 16, 'h80);
        chk("ovfl.busy", 64'(busy), 64'd0);
        drive(1, 0, 0, 'h55);
        drive(1, 0, 0, 'h66);
        drive(1, 1, 0, 'h10);
        chk("drop_head.busy", 64'(busy), 64'd1);
        drive(1, 0, 1, 'h20);
        lit_rec("after_drop", 0, 0, 2, 'h30);

        // Overflow, tail leaves drop silently, then an orphan in idle.
        drive(1, 1, 0, 'h00);
        for (int i = 0; i < 15; i++) drive(1, 0, 0, 'h3C);
        drive(1, 0, 1, 'h00);
        drive(1, 0, 0, 'h07);
        lit_rec("orphan2", 1, 1, 1, 'h07);

        // Exactly MAX_LEN beats ending in a tail is good.
        drive(1, 1, 0, 1);
        for (int i = 2; i <= 15; i++) drive(1, 0, 0, i);
        drive(1, 0, 1, 16);
        lit_rec("full", 0, 0, 16, 'h10);

        // Reset mid-packet drops it silently.
        drive(1, 1, 0, 'hC3);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 'h5A);
        do_reset();
        drive(1, 1, 0, 'h01);
        drive(1, 0, 1, 'h01);
        lit_rec("post_rst", 0, 0, 2, 'h00);
        chk("post_rst.good", 64'(good_cnt), 64'd1);

        // Counter saturation.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, i);
            drive(1, 0, 1, i + 1);
        end
        chk("sat.good", 64'(good_cnt), 64'(CMAX));
        for (int i = 0; i < 9; i++) drive(1, 0, 0, i);
        chk("sat.errc", 64'(err_cnt), 64'(CMAX));
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
